bsg_ready_to_credit_flow_converter_multi: RTL and testbench
===========================================================

# bsg_ready_to_credit_flow_converter_multi

Converts `channels_p` independent valid/ready producer interfaces into credit-based links toward remote receivers. Each channel has its own credit counter. The remote side can return credits in batches of `decimation_p` per pulse, and the counter can start pre-loaded with credits. The block sits at the boundary between on-chip ready/valid logic and credit-flow links such as off-chip or long-wire channels. It is the parametrised successor of the single-channel, fixed-depth converter.

## Interface
- `channels_p`, 1, number of independent channels.
- `credit_initial_p`, 0, credits each channel holds after reset.
- `credit_max_val_p`, 10, maximum credits a channel may hold. Counter width `cw_lp = $clog2(credit_max_val_p+1)`.
- `decimation_p`, 1, credits restored by one `credit_i` pulse.
- Legal ranges (elaboration check):
  - `channels_p >= 1`, `decimation_p >= 1`
  - `credit_initial_p <= credit_max_val_p`
  - `decimation_p <= credit_max_val_p`
- `clk_i`  in  1  sole clock; all state updates on the rising edge.
- `reset_i`  in  1  synchronous, active-high reset.
- `v_i`  in  `channels_p`  producer valid, per channel.
- `ready_o`  out  `channels_p`  channel holds ≥1 credit.
- `v_o`  out  `channels_p`  valid launched onto credit link.
- `credit_i`  in  `channels_p`  one pulse = `decimation_p` credits returned.
- `credit_cnt_o`  out  `channels_p*cw_lp`  current credit count; channel i at bits [i*cw_lp +: cw_lp].
- `error_o`  out  `channels_p`  sticky credit-overflow flag (see Configuration).

## Operation
- Channels are fully independent. No shared state and no arbitration between channels.
- Per channel, `ready_o[i] = (cnt[i] != 0)`. This is purely combinational from the register; it never depends on `v_i`.
- `v_o[i] = v_i[i] & ready_o[i]`. Combinational. The producer's transfer equals `v_o[i]`.
- Counter update each cycle: `cnt_next = cnt - v_o[i] + (credit_i[i] ? decimation_p : 0)`.
  - Compute in `cw_lp+1` bits so overflow is detectable.
- Send and credit return in the same cycle: both apply, giving a net change of `decimation_p - 1`.
- `cnt == 0` with `credit_i` asserted: `ready_o` stays 0 this cycle and `v_o` is suppressed. The count becomes `decimation_p` next cycle.
- Overflow is defined as `cnt_next > credit_max_val_p`. It indicates a receiver protocol violation. Handling depends on `BSG_RTCFC_OVERFLOW_CHECK_EN`.
- Underflow cannot occur, because `v_o` is gated by `ready_o`.

## Timing
- While `reset_i` is asserted:
  - every `cnt` loads `credit_initial_p` on the next edge;
  - `error_o` clears to 0.
- After reset:
  - `credit_cnt_o = credit_initial_p`;
  - `ready_o = (credit_initial_p != 0)` on all channels;
  - `v_o = v_i & ready_o`.
- During reset, `ready_o` and `v_o` still follow the current register value. Once the reset edge has taken effect, they follow the reset state.
- Reset mid-operation discards all outstanding credit accounting. There is no drain.
- Latency:
  - `v_i` → `v_o`: 0 cycles.
  - A consumed credit is reflected in `credit_cnt_o`/`ready_o` 1 cycle after the `v_o` edge.
  - A returned credit becomes usable 1 cycle after the `credit_i` edge.
- Throughput: 1 send per channel per cycle while `cnt ≥ 1`. With `cnt == 1` and no credit return, the channel sends once, then `ready_o` is 0 the next cycle.

## Configuration
- Macro: `BSG_RTCFC_OVERFLOW_CHECK_EN`.
- Defined:
  - on overflow, `cnt` saturates at `credit_max_val_p`;
  - `error_o[i]` sets on the following edge and stays set until reset;
  - a simulation-only `$error` message names the channel index.
- Undefined:
  - no compare logic is built;
  - `cnt_next` is truncated to `cw_lp` bits (wraps modulo 2^cw_lp);
  - `error_o` is tied to 0.

## Test plan
- Reset, `credit_initial_p=0`, `channels_p=2`, `decimation_p=1` → `ready_o=2'b00`, `credit_cnt_o=0`. Then pulse `credit_i[0]` once → next cycle `ready_o=2'b01` and channel 0 count = 1. With `v_i=2'b11` held: exactly one `v_o[0]` pulse, `v_o[1]` never asserts.
- `credit_initial_p=4`, `v_i[0]` held high for 6 cycles, no credits → `v_o[0]` high for 4 cycles, then 0. Count sequence 4,3,2,1,0.
- `decimation_p=4`, `credit_max_val_p=8`, `cnt=2`, `v_o` and `credit_i` in the same cycle → next count = 5.
- `cnt=0`, `v_i=1` and `credit_i=1` in the same cycle → `v_o=0` that cycle. Next cycle count = `decimation_p`, `v_o=1`.
- With the macro defined, `credit_max_val_p=10`, `cnt=10`, `credit_i` pulse → count stays 10 and `error_o` goes to 1 next cycle, remaining 1 until reset. Without the macro, the same stimulus wraps the count to 11 (`cw_lp=4`) and `error_o` stays 0.
- Reset asserted mid-stream with `cnt=3` and `error_o=1` → next cycle count = `credit_initial_p` and `error_o=0`. Subsequent traffic matches a fresh-reset run.

Source files
------------

// File: rtl/bsg_ready_to_credit_flow_converter_multi.sv
// Per-channel ready/valid to credit-flow converter with batched credit return.
// Optional overflow saturation and sticky error via BSG_RTCFC_OVERFLOW_CHECK_EN.
module bsg_ready_to_credit_flow_converter_multi #(
  parameter int channels_p       = 1,
  parameter int credit_initial_p = 0,
  parameter int credit_max_val_p = 10,
  parameter int decimation_p     = 1,
  localparam int cw_lp           = $clog2(credit_max_val_p + 1)
) (
  input  logic                          clk_i,
  input  logic                          reset_i,
  input  logic [channels_p-1:0]         v_i,
  output logic [channels_p-1:0]         ready_o,
  output logic [channels_p-1:0]         v_o,
  input  logic [channels_p-1:0]         credit_i,
  output logic [channels_p*cw_lp-1:0]   credit_cnt_o,
  output logic [channels_p-1:0]         error_o
);

  if (channels_p < 1 || decimation_p < 1
      || credit_initial_p > credit_max_val_p
      || decimation_p > credit_max_val_p) begin : g_param_check
    $error("bsg_ready_to_credit_flow_converter_multi: illegal parameter combination");
  end

  localparam logic [cw_lp-1:0] init_lp = cw_lp'(credit_initial_p);

  logic [channels_p-1:0][cw_lp-1:0] cnt_r;
  logic [channels_p-1:0][cw_lp-1:0] cnt_next;

  assign credit_cnt_o = cnt_r;

`ifdef BSG_RTCFC_OVERFLOW_CHECK_EN
  localparam logic [cw_lp:0] dec_wide_lp = (cw_lp + 1)'(decimation_p);
  localparam logic [cw_lp:0] max_wide_lp = (cw_lp + 1)'(credit_max_val_p);

  function automatic logic is_overflow(input logic [cw_lp:0] sum);
    is_overflow = (sum > max_wide_lp);
  endfunction

  function automatic logic [cw_lp-1:0] sat_cnt(input logic [cw_lp:0] sum);
    if (sum > max_wide_lp)
      sat_cnt = cw_lp'(credit_max_val_p);
    else
      sat_cnt = sum[cw_lp-1:0];
  endfunction

  logic [channels_p-1:0] overflow;
  logic [channels_p-1:0] error_r;

  assign error_o = error_r;
`else
  localparam logic [cw_lp-1:0] dec_lp = cw_lp'(decimation_p);

  assign error_o = '0;
`endif

  for (genvar i = 0; i < channels_p; i++) begin : g_ch
    // Ready comes only from the stored count so it never loops back through v_i.
    assign ready_o[i] = (cnt_r[i] != '0);
    assign v_o[i]     = v_i[i] & ready_o[i];

`ifdef BSG_RTCFC_OVERFLOW_CHECK_EN
    logic [cw_lp:0] sum;
    assign sum = {1'b0, cnt_r[i]} - (cw_lp + 1)'(v_o[i])
               + (credit_i[i] ? dec_wide_lp : '0);
    assign overflow[i] = is_overflow(sum);
    assign cnt_next[i] = sat_cnt(sum);

    always_ff @(posedge clk_i) begin
      if (reset_i)
        error_r[i] <= 1'b0;
      else if (overflow[i])
        error_r[i] <= 1'b1;
    end

`ifndef SYNTHESIS
    always_ff @(posedge clk_i) begin
      if (!reset_i && overflow[i])
        $error("bsg_ready_to_credit_flow_converter_multi: credit overflow on channel %0d", i);
    end
`endif
`else
    // Without the check the sum is kept at counter width and simply wraps.
    assign cnt_next[i] = cnt_r[i] - cw_lp'(v_o[i])
                       + (credit_i[i] ? dec_lp : '0);
`endif

    always_ff @(posedge clk_i) begin
      if (reset_i)
        cnt_r[i] <= init_lp;
      else
        cnt_r[i] <= cnt_next[i];
    end
  end

endmodule

// File: tb/tb_bsg_ready_to_credit_flow_converter_multi.sv
// Randomized scoreboard bench for bsg_ready_to_credit_flow_converter_multi.
module tb_bsg_ready_to_credit_flow_converter_multi;

  localparam int C    = 3;
  localparam int INIT = 2;
  localparam int MAX  = 10;
  localparam int DEC  = 3;
  localparam int CW   = $clog2(MAX + 1);

  logic            clk = 1'b0;
  logic            reset_i;
  logic [C-1:0]    v_i;
  logic [C-1:0]    ready_o;
  logic [C-1:0]    v_o;
  logic [C-1:0]    credit_i;
  logic [C*CW-1:0] credit_cnt_o;
  logic [C-1:0]    error_o;

  bsg_ready_to_credit_flow_converter_multi #(
    .channels_p(C), .credit_initial_p(INIT),
    .credit_max_val_p(MAX), .decimation_p(DEC)
  ) dut (
    .clk_i(clk), .reset_i(reset_i), .v_i(v_i), .ready_o(ready_o), .v_o(v_o),
    .credit_i(credit_i), .credit_cnt_o(credit_cnt_o), .error_o(error_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [C-1:0]    ready;
    logic [C-1:0]    vo;
    logic [C*CW-1:0] cnt;
    logic [C-1:0]    err;
  } exp_t;

  exp_t exp_q[$];
  int   vectors = 0;
  int   miscompares = 0;

  // Reference model: plain integer credit counts per channel.
  int cnt_m[C];
  bit err_m[C];

  task automatic step(input bit r, input logic [C-1:0] v, input logic [C-1:0] c);
    exp_t e;
    int   n;
    reset_i  = r;
    v_i      = v;
    credit_i = c;
    e = '0;
    for (int ch = 0; ch < C; ch++) begin
      e.ready[ch]         = (cnt_m[ch] > 0);
      e.vo[ch]            = v[ch] && (cnt_m[ch] > 0);
      e.cnt[ch*CW +: CW]  = CW'(cnt_m[ch]);
      e.err[ch]           = err_m[ch];
    end
    exp_q.push_back(e);
    for (int ch = 0; ch < C; ch++) begin
      if (r) begin
        cnt_m[ch] = INIT;
        err_m[ch] = 1'b0;
      end else begin
        n = cnt_m[ch] - (e.vo[ch] ? 1 : 0) + (c[ch] ? DEC : 0);
`ifdef BSG_RTCFC_OVERFLOW_CHECK_EN
        if (n > MAX) begin
          n = MAX;
          err_m[ch] = 1'b1;
        end
`else
        n = n % (1 << CW);
`endif
        cnt_m[ch] = n;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [C*CW-1:0] got, input logic [C*CW-1:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, got, want);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("ready_o",      (C*CW)'(ready_o), (C*CW)'(e.ready));
      check("v_o",          (C*CW)'(v_o),     (C*CW)'(e.vo));
      check("credit_cnt_o", credit_cnt_o,     e.cnt);
      check("error_o",      (C*CW)'(error_o), (C*CW)'(e.err));
    end
  end

  initial begin
    reset_i  = 1'b1;
    v_i      = '0;
    credit_i = '0;
    @(posedge clk);
    #1;
    for (int ch = 0; ch < C; ch++) begin
      cnt_m[ch] = INIT;
      err_m[ch] = 1'b0;
    end
    step(1'b1, '0, '0);
    // Drain all channels with valid held high and no credit return.
    for (int k = 0; k < 4; k++) step(1'b0, '1, '0);
    // Credit return while empty and valid high: send suppressed this cycle.
    step(1'b0, 3'b001, 3'b001);
    step(1'b0, 3'b001, 3'b000);
    // Send and return in the same cycle.
    step(1'b0, 3'b001, 3'b001);
    // Push channel 1 past its maximum.
    for (int k = 0; k < 5; k++) step(1'b0, 3'b000, 3'b010);
    step(1'b0, 3'b000, 3'b000);
    // Reset mid-stream, then fresh traffic.
    step(1'b1, 3'b111, 3'b111);
    for (int k = 0; k < 3; k++) step(1'b0, 3'b111, 3'b000);
    for (int k = 0; k < 400; k++) begin
      logic [C-1:0] v, c;
      v = C'($urandom);
      c = '0;
      for (int ch = 0; ch < C; ch++) c[ch] = ($urandom_range(0, 3) == 0);
      step($urandom_range(0, 99) == 0, v, c);
    end
    step(1'b0, '0, '0);
    @(negedge clk);
    #1;
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
